// File: rtl/wire_not_use_pkg.sv
// Shared constants for wire_not_use: default counter width and the
// saturation value of the rise counter.
package wire_not_use_pkg;

    // Default width of the rise-event counter
    localparam int CNT_W_DEF = 8;

    // Largest value a counter of width w can hold (w in 2..16)
    function automatic int unsigned cnt_sat(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/wnu_rise_det.sv
// Registered 0->1 edge detector. The pulse appears in the same cycle the
// registered copy of the level first shows 1. After reset the previous level
// is taken as 0, so a level of 1 on the first sampled edge counts as a rise.
module wnu_rise_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic level_q;

    // Track last sampled level and flag a rise when it was 0 and is now 1
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_q <= level;
            pulse   <= level & ~level_q;
        end
    end

endmodule

// File: rtl/wire_not_use.sv
// wire_not_use: registered AND/OR term with rise detection and an optional
// saturating rise counter.
// Optional feature macro: WIRE_NOT_USE_CNT_EN -- when defined, cnt_o counts
// E_rise_o pulses and saturates; when undefined, cnt_o is tied to 0.
module wire_not_use
    import wire_not_use_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             A_i,
    input  logic             B_i,
    input  logic             D_i,
    output logic             C_o,
    output logic             E_o,
    output logic             E_rise_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic c;
    logic e;

    assign c = A_i & B_i;
    assign e = c | D_i;

    // One-cycle registered copies of the intermediate and final terms
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            C_o <= 1'b0;
            E_o <= 1'b0;
        end else begin
            C_o <= c;
            E_o <= e;
        end
    end

    // Rise pulse is aligned with the first cycle E_o shows 1
    wnu_rise_det u_rise (
        .clk   (clk_i),
        .rst   (rst_i),
        .level (e),
        .pulse (E_rise_o)
    );

`ifdef WIRE_NOT_USE_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat(CNT_W));

    // Count rise pulses; the count moves at the edge that closes a pulse
    // cycle and sticks at the maximum instead of wrapping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (E_rise_o && (cnt_o != CNT_MAX)) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end
`else
    assign cnt_o = '0;
`endif

endmodule

// File: tb/tb_wire_not_use.sv
// Self-checking bench for wire_not_use: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_wire_not_use;

`ifdef WIRE_NOT_USE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a = 1'b0, b = 1'b0, d = 1'b0;

    logic       c8, e8, r8;
    logic [7:0] cnt8;
    logic       c2, e2, r2;
    logic [1:0] cnt2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wire_not_use #(.CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .A_i(a), .B_i(b), .D_i(d),
        .C_o(c8), .E_o(e8), .E_rise_o(r8), .cnt_o(cnt8)
    );

    wire_not_use #(.CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .A_i(a), .B_i(b), .D_i(d),
        .C_o(c2), .E_o(e2), .E_rise_o(r2), .cnt_o(cnt2)
    );

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int ce(input int v);
        return CNT_EN ? v : 0;
    endfunction

    // Behavioural model: outputs are the previous edge's logic values; a rise
    // is "e now 1, last registered e was 0"; the count is the number of rises
    // in earlier cycles since reset, clipped to the counter's maximum.
    bit m_valid = 1'b0;
    bit m_c, m_e, m_rise;
    int m_prior;

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b1;
            m_c     <= 1'b0;
            m_e     <= 1'b0;
            m_rise  <= 1'b0;
            m_prior <= 0;
        end else begin
            m_c     <= a && b;
            m_e     <= (a && b) || d;
            m_rise  <= ((a && b) || d) && !m_e;
            m_prior <= m_prior + (m_rise ? 1 : 0);
        end
    end

    function automatic int exp_cnt(input int w);
        int mx;
        mx = (1 << w) - 1;
        return ce(m_prior > mx ? mx : m_prior);
    endfunction

    // Compare every cycle once reset has been seen
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_C8",    int'(c8),   int'(m_c));
            check("model_E8",    int'(e8),   int'(m_e));
            check("model_rise8", int'(r8),   int'(m_rise));
            check("model_cnt8",  int'(cnt8), exp_cnt(8));
            check("model_C2",    int'(c2),   int'(m_c));
            check("model_E2",    int'(e2),   int'(m_e));
            check("model_rise2", int'(r2),   int'(m_rise));
            check("model_cnt2",  int'(cnt2), exp_cnt(2));
        end
    end

    // Drive inputs mid-cycle, then land on the next falling edge where the
    // outputs reflect them
    task automatic apply(input bit ia, input bit ib, input bit id, input bit ir);
        a = ia; b = ib; d = id; rst = ir;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect8(input string nm, input int ec, input int ee,
                           input int er, input int ecnt);
        check({nm, "_C"},    int'(c8),   ec);
        check({nm, "_E"},    int'(e8),   ee);
        check({nm, "_rise"}, int'(r8),   er);
        check({nm, "_cnt"},  int'(cnt8), ecnt);
    endtask

    initial begin
        // sequence 100,110,111,010,011,001 and its expected results
        bit [2:0] seq   [6] = '{3'b100, 3'b110, 3'b111, 3'b010, 3'b011, 3'b001};
        int       sc    [6] = '{0, 1, 1, 0, 0, 0};
        int       se    [6] = '{0, 1, 1, 0, 1, 1};
        int       sr    [6] = '{0, 1, 0, 0, 1, 0};
        int       scnt  [6] = '{0, 0, 1, 1, 1, 2};
        int       tcnt  [5] = '{1, 2, 3, 3, 3};

        @(negedge clk);
        apply(0, 0, 0, 1);
        apply(0, 0, 0, 1);
        expect8("reset", 0, 0, 0, 0);
        check("reset_cnt2", int'(cnt2), 0);

        apply(0, 0, 0, 0);
        expect8("idle000", 0, 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            apply(seq[i][2], seq[i][1], seq[i][0], 0);
            expect8($sformatf("seq%0d", i), sc[i], se[i], sr[i], ce(scnt[i]));
        end

        // hold D high for 10 cycles from E=0: one pulse, one increment
        apply(0, 0, 0, 0);
        expect8("pre_hold", 0, 0, 0, ce(2));
        apply(0, 0, 1, 0);
        expect8("hold_first", 0, 1, 1, ce(2));
        for (int i = 1; i < 10; i++) begin
            apply(0, 0, 1, 0);
            expect8($sformatf("hold%0d", i), 0, 1, 0, ce(3));
        end

        // narrow counter saturates at 3 over five rises
        apply(0, 0, 0, 1);
        check("sat_reset_cnt2", int'(cnt2), 0);
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 1, 0);
            check($sformatf("sat_rise%0d", i), int'(r2), 1);
            apply(0, 0, 0, 0);
            check($sformatf("sat_cnt%0d", i), int'(cnt2), ce(tcnt[i]));
        end
        apply(0, 0, 0, 0);
        check("sat_hold_cnt2", int'(cnt2), ce(3));

        // reset in the cycle a rise would land wins, then first cycle rises
        apply(0, 0, 1, 1);
        expect8("rst_vs_rise", 0, 0, 0, 0);
        check("rst_vs_rise_cnt2", int'(cnt2), 0);
        apply(0, 0, 1, 0);
        expect8("post_rst_rise", 0, 1, 1, 0);
        apply(1, 1, 1, 0);
        expect8("post_rst_cnt", 1, 1, 0, ce(1));

        // mixed traffic checked only by the model
        for (int i = 0; i < 60; i++) begin
            apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 19) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wire_not_use.md
WIRE_NOT_USE -- requirements
Module: wire_not_use

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the width of the event counter output cnt_o (legal range 2..16).
REQ-002 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  SHALL be the reset; synchronous, active-high.
REQ-004 A_i  input  1  SHALL be first AND operand.
REQ-005 B_i  input  1  SHALL be second AND operand.
REQ-006 D_i  input  1  SHALL be OR operand (override term).
REQ-007 C_o  output  1  SHALL carry the registered intermediate term A_i & B_i.
REQ-008 E_o  output  1  SHALL carry the registered result (A_i & B_i) | D_i.
REQ-009 E_rise_o  output  1  SHALL pulse one cycle when E_o goes 0->1.
REQ-010 cnt_o  output  CNT_W  SHALL carry the saturating count of E_o rising edges.

Function
REQ-011 The combinational term c = A_i & B_i SHALL be formed internally; e = c | D_i.
REQ-012 C_o and E_o SHALL equal c and e sampled at the previous rising clk_i edge (latency exactly 1 cycle, no combinational input-to-output path).
REQ-013 Truth table for E_o one cycle after sampling (A,B,D): 000->0, 100->0, 110->1, 111->1, 010->0, 011->1, 001->1.
REQ-014 D_i=1 SHALL force E_o=1 regardless of A_i, B_i; C_o is unaffected by D_i.
REQ-015 E_rise_o SHALL be 1 in the cycle where E_o is 1 and its previous-cycle value was 0; otherwise 0; it is registered alongside E_o (same cycle E_o first shows 1).
REQ-016 cnt_o SHALL increment by 1 on every cycle with E_rise_o=1 and SHALL hold at 2^CNT_W-1 once reached (no wrap-around).
REQ-017 E_o held at 1 for many cycles SHALL produce exactly one E_rise_o pulse and one increment.
REQ-018 The first cycle after reset deassertion SHALL treat the previous E_o as 0, so e=1 sampled then produces a rise.

Reset
REQ-019 While rst_i=1 at a rising edge, C_o, E_o, E_rise_o SHALL become 0 and cnt_o SHALL become 0.
REQ-020 Reset asserted mid-operation SHALL override all updates in that cycle, including a simultaneous rise or increment.
REQ-021 Outputs SHALL be undefined only before the first reset edge; no asynchronous behaviour.

Configuration
REQ-022 Macro WIRE_NOT_USE_CNT_EN defined: cnt_o counter SHALL be implemented per REQ-016.
REQ-023 Macro WIRE_NOT_USE_CNT_EN undefined: cnt_o port SHALL remain present and be tied to 0; no counter flops; all other behaviour unchanged.

Structure
REQ-024 Package wire_not_use_pkg SHALL hold the CNT_W default constant and the counter saturation value function/constant.
REQ-025 The rise detector SHALL be one sub-module, wnu_rise_det (input level, clk, rst; output pulse); logic of REQ-011/012 stays in the top.

Verification
REQ-026 Reset 2 cycles, then A,B,D=0,0,0 -> next cycle C_o=0, E_o=0, E_rise_o=0, cnt_o=0.
REQ-027 Apply sequence 100,110,111,010,011,001 one per cycle -> E_o next-cycle 0,1,1,0,1,1; C_o 0,1,1,0,0,0.
REQ-028 Same sequence -> E_rise_o pulses at the 110 result and the 011 result only; cnt_o ends at 2 (macro defined) or 0 (undefined).
REQ-029 Hold D_i=1 for 10 cycles after E_o=0 -> one E_rise_o pulse, cnt_o +1, E_o stays 1.
REQ-030 CNT_W=2, toggle D_i 0/1 for 5 rises -> cnt_o reaches 3 and stays 3.
REQ-031 Assert rst_i in the cycle a rise would occur -> E_o=0, E_rise_o=0, cnt_o=0 next cycle.
